ripple_count_sampler: RTL

- Downstream consumer of the 4-bit asynchronous ripple up-counter. The ripple counter is clocked by a slow event/clock source unrelated to clk.
- The block brings the counter's skewed, multi-bit-transitioning outputs safely into the clk domain and accumulates total increments over a programmable window of clk cycles.
- It presents the result on a valid/ready handshake, giving a frequency/event meter built on the ripple counter.

---
 rtl/ripple_count_sampler.sv | 99 +++++++++
 1 files changed

// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: synchronises a free-running ripple counter into clk and
// accumulates its increments over a programmable window, returned on valid/ready.
module ripple_count_sampler #(
    parameter int CNT_W = 4,
    parameter int ACC_W = 16,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] ripple_q,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_count,
    output logic             res_ovf
);
    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] s1_q, s2_q, s3_q, base_q, base_d, delta;
    logic [WIN_W-1:0] win_reg_q, win_reg_d, win_cnt_q, win_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0] sum;
    logic ovf_q, ovf_d, stable, last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            base_q    <= '0;
            win_reg_q <= '0;
            win_cnt_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= ripple_q;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            base_q    <= base_d;
            win_reg_q <= win_reg_d;
            win_cnt_q <= win_cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
        end
    end

    // A repeated sample cannot be a ripple intermediate code
    assign stable = s2_q == s3_q;
    assign delta  = s2_q - base_q;
    assign sum    = {1'b0, acc_q} + (ACC_W+1)'(delta);
    assign last   = win_cnt_q == win_reg_q - WIN_W'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ARM;
            ARM:     if (stable) state_d = win_reg_q == '0 ? DONE : MEASURE;
            MEASURE: if (last) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_reg_d = win_reg_q;
        win_cnt_d = win_cnt_q;
        base_d    = base_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        if (state_q == IDLE && start) begin
            win_reg_d = win_len;
            acc_d     = '0;
            ovf_d     = 1'b0;
        end
        if (state_q == ARM && stable) begin
            base_d    = s2_q;
            win_cnt_d = '0;
        end
        if (state_q == MEASURE) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (stable) begin
                base_d = s2_q;
                acc_d  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                ovf_d  = ovf_q | sum[ACC_W];
            end
        end
    end

    always_comb begin
        busy      = state_q != IDLE;
        res_valid = state_q == DONE;
        res_count = acc_q;
        res_ovf   = ovf_q;
    end
endmodule
